// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC and feeds IF/ID over a valid/ready handshake.
// Optional feature: define DELAY_SLOT_EN to keep the IF slot valid across a redirect (MIPS branch delay slot).
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [31:0]          pc_o,
    input  logic [31:0]          pc_plus4_i,
    input  logic [31:0]          instr_i,
    input  logic                 redirect_valid_i,
    input  logic [31:0]          redirect_target_i,
    output logic                 if_valid_o,
    input  logic                 if_ready_i,
    output logic [31:0]          instr_o,
    output logic [31:0]          if_pc_o,
    output logic                 fetch_adel_o,
    output logic [CNT_WIDTH-1:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pend_q, pend_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pend_valid;
    logic                 advance;
    logic                 xfer;

    // A pending redirect exists exactly while the FSM sits in PEND.
    assign pend_valid = (state_q == PEND);

`ifdef DELAY_SLOT_EN
    assign if_valid_o = (state_q != BOOT);
`else
    assign if_valid_o = (state_q == RUN) & ~redirect_valid_i;
`endif

    // Killed slots still advance the PC; only BOOT and stalls hold it.
    assign advance = (state_q != BOOT) & if_ready_i;
    assign xfer    = if_valid_o & if_ready_i;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;

        if (xfer) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (advance) begin
            state_d = RUN;
            if (redirect_valid_i) begin
                pc_d = redirect_target_i;
            end else if (pend_valid) begin
                pc_d = pend_q;
            end else begin
                pc_d = pc_plus4_i;
            end
        end else if (redirect_valid_i) begin
            // Stalled: remember the latest redirect until IF/ID accepts again.
            state_d = PEND;
            pend_d  = redirect_target_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o         = pc_q;
    assign if_pc_o      = pc_q;
    assign instr_o      = instr_i;
    assign fetch_adel_o = (pc_q[1:0] != 2'b00);
    assign fetch_cnt_o  = cnt_q;

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the P5 pipelined MIPS core.
- Owns the PC register and drives the PC+4 incrementer, which is combinational and external to this block. It consumes the incremented value from that incrementer.
- Selects the next PC from sequential, redirect and pending-redirect sources.
- Presents the fetched instruction and PC to the IF/ID register with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset (fetch entry point).
- CNT_WIDTH, 32, width of the accepted-fetch counter.

Ports:
- clk  input  1  single clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- pc_o  output  32  current PC; feeds the incrementer input and the instruction-memory address.
- pc_plus4_i  input  32  incrementer result, expected equal to pc_o+4 in the same cycle.
- instr_i  input  32  instruction-memory read data for pc_o (combinational read).
- redirect_valid_i  input  1  branch/jump resolved in ID; take redirect_target_i.
- redirect_target_i  input  32  redirect destination.
- if_valid_o  output  1  instr_o/if_pc_o are valid for IF/ID.
- if_ready_i  input  1  IF/ID accepts this cycle; low means hazard stall.
- instr_o  output  32  instruction to IF/ID, equal to instr_i.
- if_pc_o  output  32  PC of instr_o, equal to pc_o.
- fetch_adel_o  output  1  pc_o[1:0]!=0; qualified by if_valid_o.
- fetch_cnt_o  output  CNT_WIDTH  number of accepted transfers.

Behaviour:
- Reset (async, reset_n=0):
  - pc_q=RESET_PC, state=BOOT, pend_q=0, pend_valid=0, fetch_cnt_o=0.
  - if_valid_o=0 while in reset.
  - Reset may arrive mid-operation; all state clears immediately and any pending redirect is discarded.
- States:
  - BOOT: first cycle after reset release. if_valid_o=0 and pc_q holds. Unconditional transition to RUN next cycle, so the first valid fetch occurs in cycle 2 after release.
  - RUN: normal fetch.
  - PEND: a redirect was captured while stalled; pend_q holds the target.
- Transfer condition: xfer = if_valid_o & if_ready_i.
- Next-PC priority when advancing (RUN or PEND with if_ready_i=1):
  1. live redirect_valid_i → redirect_target_i;
  2. pend_valid → pend_q;
  3. otherwise pc_plus4_i.
- Entering RUN: any advance clears pend_valid, and the state goes to RUN.
- Stall (if_ready_i=0):
  - pc_q holds.
  - A live redirect is written to pend_q with pend_valid=1 and the state goes to PEND.
  - A second redirect while in PEND overwrites pend_q; the latest redirect wins.
- The PC advances even when if_valid_o=0 (killed slot), as long as if_ready_i=1. A bubble is not accepted, but it never blocks.
- Arithmetic: pc_plus4_i is taken as-is, and wrap at 32'hFFFF_FFFC → 0 is the incrementer's concern. The block does no adding.
- Misaligned PC:
  - The block never blocks on a misaligned PC; redirect_target_i is loaded unmodified.
  - fetch_adel_o=1 for the fetch at that PC.
  - The instruction is still presented so that ID/EX can raise AdEL.
- fetch_cnt_o increments by 1 on each xfer and wraps modulo 2^CNT_WIDTH.
- if_pc_o, instr_o and fetch_adel_o are combinational from pc_q and instr_i. There is no added latency: one PC per cycle when unstalled.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - The instruction currently in IF when a redirect arrives is the delay slot and remains valid. if_valid_o=1 in RUN and PEND.
  - The redirect target becomes pc_q on the next advance.
- Undefined (no delay slot):
  - The slot in IF is wrong-path.
  - if_valid_o = (state==RUN) & ~redirect_valid_i, so it is 0 in PEND and in any cycle with redirect_valid_i=1.
  - The killed slot is not counted in fetch_cnt_o.

Test Plan:
- Reset release, if_ready_i=1, no redirects:
  - pc_o sequence is 3000 (valid=0, BOOT), then 3000 (valid=1), 3004, 3008.
  - fetch_cnt_o=3 after 3 valid cycles.
- At pc=3008, pulse redirect_valid_i with target 3100 for 1 cycle, ready=1:
  - next pc=3100.
  - With DELAY_SLOT_EN, the transfer at 3008 is valid.
  - Without it, if_valid_o=0 that cycle and fetch_cnt_o does not increment.
- if_ready_i=0 for 3 cycles at pc=3010; redirect target 3200 in stall cycle 1, then 3300 in stall cycle 2:
  - pc holds 3010 during the stall, state=PEND.
  - On ready=1, next pc=3300.
- In PEND (pend=3300), ready=1 together with live redirect target 3400:
  - next pc=3400 and pend_valid clears.
- Redirect to 3002:
  - pc_o=3002, fetch_adel_o=1 with if_valid_o=1.
  - Next pc=3006 (from pc_plus4_i).
- reset_n low asynchronously mid-cycle while in PEND:
  - pc_o=3000 and if_valid_o=0 immediately; fetch_cnt_o=0.
  - After release, BOOT then RUN; the pending target is not taken.
